// File: rtl/usr_pkg.sv
// ============================================================================
//  Module      : usr_pkg
//  Description : Opcodes, FSM states and helpers for the universal shift register.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package usr_pkg;

    typedef enum logic [2:0] {
        USR_NOP   = 3'b000,
        USR_SHR   = 3'b001,
        USR_SHL   = 3'b010,
        USR_LOAD  = 3'b011,
        USR_ROR   = 3'b100,
        USR_ROL   = 3'b101,
        USR_ASR   = 3'b110,
        USR_CLEAR = 3'b111
    } usr_op_e;

    typedef enum logic {
        USR_IDLE  = 1'b0,
        USR_SHIFT = 1'b1
    } usr_state_e;

    function automatic logic is_shift_op(input usr_op_e op);
        return (op == USR_SHR) || (op == USR_SHL) || (op == USR_ROR) ||
               (op == USR_ROL) || (op == USR_ASR);
    endfunction

endpackage : usr_pkg

`default_nettype wire

// File: rtl/usr_shift_step.sv
// ============================================================================
//  Module      : usr_shift_step
//  Description : One single-bit step of any shift/rotate op (combinational).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module usr_shift_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  usr_op_e          op,
    input  logic [WIDTH-1:0] q,
    input  logic             serial_in_r,
    input  logic             serial_in_l,
    output logic [WIDTH-1:0] next_q,
    output logic             out_bit
);

    always_comb begin
        next_q  = q;
        out_bit = 1'b0;
        case (op)
            USR_SHR: begin
                next_q  = {serial_in_r, q[WIDTH-1:1]};
                out_bit = q[0];
            end
            USR_SHL: begin
                next_q  = {q[WIDTH-2:0], serial_in_l};
                out_bit = q[WIDTH-1];
            end
            USR_ROR: begin
                next_q  = {q[0], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            USR_ROL: begin
                next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
                out_bit = q[WIDTH-1];
            end
            USR_ASR: begin
                next_q  = {q[WIDTH-1], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            default: begin
                next_q  = q;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule : usr_shift_step

`default_nettype wire

// File: rtl/param_universal_shift_reg.sv
// ============================================================================
//  Module      : param_universal_shift_reg
//  Description : Universal shift register with command handshake and N-step shifts.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module param_universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 15,
    parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             serial_in_r,
    input  logic             serial_in_l,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    usr_state_e       state, state_nxt;
    usr_op_e          op_r, op_nxt;
    logic [CNT_W-1:0] remaining, remaining_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             serial_out_nxt;
    logic             done_nxt;

    usr_op_e          cmd_op_e;
    usr_op_e          step_op;
    logic [WIDTH-1:0] step_q;
    logic             step_bit;
    logic [CNT_W:0]   count_wide;
    logic [CNT_W-1:0] eff_count;
    logic             accept;

    assign cmd_op_e  = usr_op_e'(cmd_op);
    assign busy      = (state == USR_SHIFT);
    assign cmd_ready = ~busy;
    assign accept    = cmd_valid & cmd_ready;

    // Widened by one bit so the clamp compare stays meaningful for any MAX_COUNT.
    assign count_wide = {1'b0, cmd_count};
    assign eff_count  = (count_wide > (CNT_W+1)'(MAX_COUNT)) ? CNT_W'(MAX_COUNT) : cmd_count;

    // The single step engine serves the accept edge and every SHIFT cycle.
    assign step_op = (state == USR_SHIFT) ? op_r : cmd_op_e;

    usr_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op          (step_op),
        .q           (q),
        .serial_in_r (serial_in_r),
        .serial_in_l (serial_in_l),
        .next_q      (step_q),
        .out_bit     (step_bit)
    );

    always_comb begin
        state_nxt      = state;
        op_nxt         = op_r;
        remaining_nxt  = remaining;
        q_nxt          = q;
        serial_out_nxt = serial_out;
        done_nxt       = 1'b0;
        if (state == USR_SHIFT) begin
            q_nxt          = step_q;
            serial_out_nxt = step_bit;
            remaining_nxt  = remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
                state_nxt = USR_IDLE;
                done_nxt  = 1'b1;
            end
        end else if (accept) begin
            op_nxt = cmd_op_e;
            case (cmd_op_e)
                USR_NOP:   q_nxt = q;
                USR_LOAD:  q_nxt = parallel_in;
                USR_CLEAR: q_nxt = '0;
                default: begin
                    if (eff_count != '0) begin
                        q_nxt          = step_q;
                        serial_out_nxt = step_bit;
                    end
                end
            endcase
            if (is_shift_op(cmd_op_e) && (eff_count > CNT_W'(1))) begin
                state_nxt     = USR_SHIFT;
                remaining_nxt = eff_count - CNT_W'(1);
            end else begin
                done_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= USR_IDLE;
            op_r       <= USR_NOP;
            remaining  <= '0;
            q          <= '0;
            serial_out <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            op_r       <= op_nxt;
            remaining  <= remaining_nxt;
            q          <= q_nxt;
            serial_out <= serial_out_nxt;
            done       <= done_nxt;
        end
    end

endmodule : param_universal_shift_reg

`default_nettype wire

// File: tb/tb_param_universal_shift_reg.sv
// ============================================================================
//  Module      : tb_param_universal_shift_reg
//  Description : Directed self-checking bench for param_universal_shift_reg.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_param_universal_shift_reg;

    localparam int WIDTH     = 8;
    localparam int MAX_COUNT = 15;
    localparam int CNT_W     = $clog2(MAX_COUNT + 1);

    localparam logic [2:0] OP_NOP = 3'b000, OP_SHR = 3'b001, OP_SHL = 3'b010,
                           OP_LOAD = 3'b011, OP_ROR = 3'b100, OP_ROL = 3'b101,
                           OP_ASR = 3'b110, OP_CLEAR = 3'b111;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = OP_NOP;
    logic [CNT_W-1:0] cmd_count = '0;
    logic [WIDTH-1:0] parallel_in = '0;
    logic             serial_in_r = 1'b0;
    logic             serial_in_l = 1'b0;
    logic [WIDTH-1:0] q;
    logic             serial_out;
    logic             busy;
    logic             done;

    int n_vec = 0;
    int n_bad = 0;
    int cyc;

    always #5 clk = ~clk;

    param_universal_shift_reg #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_count   (cmd_count),
        .parallel_in (parallel_in),
        .serial_in_r (serial_in_r),
        .serial_in_l (serial_in_l),
        .q           (q),
        .serial_out  (serial_out),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one command for a single edge; returns 1ns after the accept edge.
    task automatic send(input logic [2:0] op, input logic [CNT_W-1:0] cnt,
                        input logic [WIDTH-1:0] pin);
        @(negedge clk);
        cmd_op      = op;
        cmd_count   = cnt;
        parallel_in = pin;
        cmd_valid   = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Counts falling edges until done is seen; -1 when the budget runs out.
    task automatic wait_done(input int limit, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!done && cycles < limit);
        if (!done) cycles = -1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_q", 32'(q), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_sout", 32'(serial_out), 32'h0);
        check("rst_ready", 32'(cmd_ready), 32'h1);
        reset_n = 1'b1;

        // LOAD 0xA5
        send(OP_LOAD, 4'd0, 8'hA5);
        @(negedge clk);
        check("load_q", 32'(q), 32'hA5);
        check("load_done", 32'(done), 32'h1);
        check("load_busy", 32'(busy), 32'h0);
        @(negedge clk);
        check("load_done_low", 32'(done), 32'h0);

        // ROR by 3: A5 -> D2 -> 69 -> B4
        send(OP_ROR, 4'd3, 8'h00);
        @(negedge clk);
        check("ror_s1_q", 32'(q), 32'hD2);
        check("ror_s1_busy", 32'(busy), 32'h1);
        check("ror_s1_done", 32'(done), 32'h0);
        @(negedge clk);
        check("ror_s2_q", 32'(q), 32'h69);
        check("ror_s2_busy", 32'(busy), 32'h1);
        @(negedge clk);
        check("ror_s3_q", 32'(q), 32'hB4);
        check("ror_s3_busy", 32'(busy), 32'h0);
        check("ror_s3_done", 32'(done), 32'h1);
        check("ror_sout", 32'(serial_out), 32'h1);
        @(negedge clk);
        check("ror_done_low", 32'(done), 32'h0);

        // ASR by 2: 90 -> C8 -> E4
        send(OP_LOAD, 4'd0, 8'h90);
        send(OP_ASR, 4'd2, 8'h00);
        wait_done(20, cyc);
        check("asr_cycles", 32'(cyc), 32'd2);
        check("asr_q", 32'(q), 32'hE4);
        check("asr_sout", 32'(serial_out), 32'h0);

        // CLEAR
        send(OP_CLEAR, 4'd5, 8'hFF);
        wait_done(20, cyc);
        check("clr_cycles", 32'(cyc), 32'd1);
        check("clr_q", 32'(q), 32'h00);

        // SHL by 10 filling ones
        serial_in_l = 1'b1;
        send(OP_SHL, 4'd10, 8'h00);
        wait_done(30, cyc);
        check("shl_cycles", 32'(cyc), 32'd10);
        check("shl_q", 32'(q), 32'hFF);
        check("shl_sout", 32'(serial_out), 32'h1);
        serial_in_l = 1'b0;

        // SHR by 0: nothing moves, done still pulses
        send(OP_SHR, 4'd0, 8'h00);
        wait_done(20, cyc);
        check("shr0_cycles", 32'(cyc), 32'd1);
        check("shr0_q", 32'(q), 32'hFF);
        check("shr0_sout", 32'(serial_out), 32'h1);

        // NOP keeps q
        send(OP_NOP, 4'd7, 8'h12);
        wait_done(20, cyc);
        check("nop_cycles", 32'(cyc), 32'd1);
        check("nop_q", 32'(q), 32'hFF);

        // Largest count (all-ones cmd_count, clamped): ROR 15 of 01 = ROL 1 -> 02
        send(OP_LOAD, 4'd0, 8'h01);
        send(OP_ROR, '1, 8'h00);
        wait_done(40, cyc);
        check("max_cycles", 32'(cyc), 32'd15);
        check("max_q", 32'(q), 32'h02);

        // cmd_valid held while busy; opcode change during SHIFT has no effect
        @(negedge clk);
        cmd_op    = OP_ROL;
        cmd_count = 4'd2;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("hold_s1_q", 32'(q), 32'h04);
        check("hold_s1_busy", 32'(busy), 32'h1);
        cmd_op      = OP_LOAD;
        parallel_in = 8'h55;
        @(negedge clk);
        check("hold_s2_q", 32'(q), 32'h08);
        check("hold_s2_done", 32'(done), 32'h1);
        check("hold_s2_ready", 32'(cmd_ready), 32'h1);
        @(negedge clk);
        check("hold_load_q", 32'(q), 32'h55);
        check("hold_load_done", 32'(done), 32'h1);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("hold_done_low", 32'(done), 32'h0);

        // Reset in the middle of an 8-step ROR
        send(OP_LOAD, 4'd0, 8'h81);
        send(OP_ROR, 4'd8, 8'h00);
        repeat (2) @(negedge clk);
        check("mid_busy", 32'(busy), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_q", 32'(q), 32'h00);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_done", 32'(done), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) cyc++;
        end
        check("mid_no_done", 32'(cyc), 32'd0);
        send(OP_LOAD, 4'd0, 8'h3C);
        wait_done(20, cyc);
        check("post_rst_cycles", 32'(cyc), 32'd1);
        check("post_rst_q", 32'(q), 32'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_param_universal_shift_reg

`default_nettype wire
